// File: rtl/hazard_sched_if.sv
// ---------------------------------------------------------------------------
// hazard_sched_if
//   Bundle of the signals exchanged between the 5-stage pipeline and the
//   hazard scheduler. The pipeline side uses the master modport (it drives
//   the stage register indices and controls). The hazard unit uses the slave
//   modport (it drives the forwarding selects, stall/flush/bubble controls,
//   multi-cycle sequencing strobes and performance counters).
//
//   Pipeline -> hazard unit:
//     Rs1_D, Rs2_D          source registers of the Decode instruction
//     Rs1_E, Rs2_E          source registers of the Execute instruction
//     RD_E, RD_M, RD_W      destination registers in E / M / W
//     RegWriteM, RegWriteW  destination write enables in M / W
//     ResultSrcE            Execute instruction is a load
//     PCSrcE                branch/jump taken in Execute
//     MultiCycleE           Execute instruction is multi-cycle (MUL/DIV)
//   Hazard unit -> pipeline:
//     ForwardA_E/B_E        2'b00 regfile, 2'b10 ALU_ResultM, 2'b01 ResultW
//     StallF/D/E            hold PC / IF-ID / ID-EX registers
//     FlushD/E              clear IF-ID / ID-EX registers
//     BubbleM               force EX-MEM control to NOP
//     MCStartE              launch pulse for the multi-cycle unit
//     MCDoneE               final Execute cycle of a multi-cycle op
//     StallCount/FlushCount performance counters
// ---------------------------------------------------------------------------
interface hazard_sched_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] Rs1_D;
    logic [REG_ADDR_W-1:0] Rs2_D;
    logic [REG_ADDR_W-1:0] Rs1_E;
    logic [REG_ADDR_W-1:0] Rs2_E;
    logic [REG_ADDR_W-1:0] RD_E;
    logic [REG_ADDR_W-1:0] RD_M;
    logic [REG_ADDR_W-1:0] RD_W;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic                  ResultSrcE;
    logic                  PCSrcE;
    logic                  MultiCycleE;

    logic [1:0]            ForwardA_E;
    logic [1:0]            ForwardB_E;
    logic                  StallF;
    logic                  StallD;
    logic                  StallE;
    logic                  FlushD;
    logic                  FlushE;
    logic                  BubbleM;
    logic                  MCStartE;
    logic                  MCDoneE;
    logic [CNT_W-1:0]      StallCount;
    logic [CNT_W-1:0]      FlushCount;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiCycleE,
        input  ForwardA_E, ForwardB_E, StallF, StallD, StallE,
        input  FlushD, FlushE, BubbleM, MCStartE, MCDoneE,
        input  StallCount, FlushCount
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiCycleE,
        output ForwardA_E, ForwardB_E, StallF, StallD, StallE,
        output FlushD, FlushE, BubbleM, MCStartE, MCDoneE,
        output StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_sched_unit.sv
// ---------------------------------------------------------------------------
// hazard_sched_unit
//   Pipeline hazard controller / scheduler for the 5-stage core.
//   - Execute-stage forwarding selects (M beats W, x0 never forwarded).
//   - Load-use detection: stall F/D and bubble E.
//   - Taken branch/jump in E: flush D/E.
//   - Multi-cycle Execute ops (MUL/DIV): a two-state countdown FSM holds
//     F/D/E and injects M bubbles for MC_LATENCY-1 cycles, then signals
//     the final Execute cycle with MCDoneE.
//   All decisions are combinational in the cycle the inputs are presented;
//   only the FSM and the performance counters are registered.
//
// Ports
//   clk  : pipeline clock
//   rst  : asynchronous, active-low reset
//   bus  : hazard_sched_if.slave (see hazard_sched_if for the signal list)
//
// Parameters
//   MC_LATENCY : cycles a multi-cycle op occupies Execute (>= 2)
//   REG_ADDR_W : register index width
//   CNT_W      : performance counter width
//
// Configuration macro
//   HAZARD_PERF_CNT_EN : when defined, StallCount counts cycles with
//                        StallF=1 and FlushCount counts cycles with
//                        FlushE=1 (both wrap). When undefined, both
//                        counters are tied to zero.
// ---------------------------------------------------------------------------
module hazard_sched_unit #(
    parameter int MC_LATENCY = 4,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_sched_if.slave       bus
);

    // Countdown width: holds MC_LATENCY-2 at most.
    localparam int CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
    localparam logic [CW-1:0]         CNT_LOAD = CW'(MC_LATENCY - 2);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
    localparam logic [REG_ADDR_W-1:0] REG_X0   = {REG_ADDR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_t;

    mc_state_t     r_state;
    mc_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic          w_mc_stall;
    logic          w_mc_start;
    logic          w_mc_done;
    logic          w_lw_stall;

    logic [1:0]    w_fwd_a;
    logic [1:0]    w_fwd_b;
    logic          w_stall_f;
    logic          w_stall_d;
    logic          w_stall_e;
    logic          w_flush_d;
    logic          w_flush_e;
    logic          w_bubble_m;

    // Forwarding select for one Execute source operand. The younger result
    // (in M) wins over the older one (in W); register x0 is hardwired to zero
    // and must always come from the register file.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != REG_X0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != REG_X0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Operand forwarding selects for the Execute stage.
    always_comb begin
        w_fwd_a = fwd_sel(bus.Rs1_E, bus.RD_M, bus.RegWriteM, bus.RD_W, bus.RegWriteW);
        w_fwd_b = fwd_sel(bus.Rs2_E, bus.RD_M, bus.RegWriteM, bus.RD_W, bus.RegWriteW);
    end

    // Load-use hazard: a load in E whose destination is read by the D instr.
    always_comb begin
        w_lw_stall = bus.ResultSrcE && (bus.RD_E != REG_X0) &&
                     ((bus.RD_E == bus.Rs1_D) || (bus.RD_E == bus.Rs2_D));
    end

    // Multi-cycle FSM state and countdown registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Multi-cycle FSM next state and strobes. The op is held in E for
    // MC_LATENCY cycles: the IDLE launch cycle, MC_LATENCY-2 BUSY cycles with
    // a non-zero count, and the final BUSY cycle at count zero, which releases
    // the pipeline. While reset is asserted no strobe or stall is produced, so
    // an op in flight is abandoned at once.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mc_stall  = 1'b0;
        w_mc_start  = 1'b0;
        w_mc_done   = 1'b0;
        if (!rst) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.MultiCycleE) begin
                        w_mc_stall  = 1'b1;
                        w_mc_start  = 1'b1;
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != CNT_ZERO) begin
                        w_mc_stall = 1'b1;
                        w_cnt_nxt  = r_cnt - CNT_ONE;
                    end else begin
                        w_mc_done   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // Prioritised stall/flush/bubble decision. A multi-cycle hold masks the
    // load-use check (the D instr simply waits longer); a taken redirect wins
    // over load-use because the D instr is discarded anyway.
    always_comb begin
        w_stall_f  = 1'b0;
        w_stall_d  = 1'b0;
        w_stall_e  = 1'b0;
        w_flush_d  = 1'b0;
        w_flush_e  = 1'b0;
        w_bubble_m = 1'b0;
        if (w_mc_stall) begin
            w_stall_f  = 1'b1;
            w_stall_d  = 1'b1;
            w_stall_e  = 1'b1;
            w_bubble_m = 1'b1;
        end else if (bus.PCSrcE) begin
            w_flush_d  = 1'b1;
            w_flush_e  = 1'b1;
        end else if (w_lw_stall) begin
            w_stall_f  = 1'b1;
            w_stall_d  = 1'b1;
            w_flush_e  = 1'b1;
        end else begin
            w_stall_f  = 1'b0;
        end
    end

    assign bus.ForwardA_E = w_fwd_a;
    assign bus.ForwardB_E = w_fwd_b;
    assign bus.StallF     = w_stall_f;
    assign bus.StallD     = w_stall_d;
    assign bus.StallE     = w_stall_e;
    assign bus.FlushD     = w_flush_d;
    assign bus.FlushE     = w_flush_e;
    assign bus.BubbleM    = w_bubble_m;
    assign bus.MCStartE   = w_mc_start;
    assign bus.MCDoneE    = w_mc_done;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    // Performance counters: cycles with a fetch stall / an Execute flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= {CNT_W{1'b0}};
            r_flush_count <= {CNT_W{1'b0}};
        end else begin
            if (w_stall_f) begin
                r_stall_count <= r_stall_count + PERF_ONE;
            end
            if (w_flush_e) begin
                r_flush_count <= r_flush_count + PERF_ONE;
            end
        end
    end

    assign bus.StallCount = r_stall_count;
    assign bus.FlushCount = r_flush_count;
`else
    assign bus.StallCount = {CNT_W{1'b0}};
    assign bus.FlushCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_sched_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_sched_unit
//   Directed test of hazard_sched_unit with hand-computed expectations.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   1 time unit after inputs settle, well away from the clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_sched_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    hazard_sched_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();

    hazard_sched_unit #(
        .MC_LATENCY (4),
        .REG_ADDR_W (5),
        .CNT_W      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.Rs1_D = 5'd0; bus.Rs2_D = 5'd0;
        bus.Rs1_E = 5'd0; bus.Rs2_E = 5'd0;
        bus.RD_E  = 5'd0; bus.RD_M  = 5'd0; bus.RD_W = 5'd0;
        bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
        bus.ResultSrcE = 1'b0; bus.PCSrcE = 1'b0; bus.MultiCycleE = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Check the multi-cycle related outputs as a packed group.
    task automatic check_mc(input string tag, input logic start, input logic done,
                            input logic stall, input logic flush_e);
        check_val({tag, ".start"},  {31'd0, bus.MCStartE}, {31'd0, start});
        check_val({tag, ".done"},   {31'd0, bus.MCDoneE},  {31'd0, done});
        check_val({tag, ".stallE"}, {31'd0, bus.StallE},   {31'd0, stall});
        check_val({tag, ".stallF"}, {31'd0, bus.StallF},   {31'd0, stall});
        check_val({tag, ".bubM"},   {31'd0, bus.BubbleM},  {31'd0, stall});
        check_val({tag, ".flushE"}, {31'd0, bus.FlushE},   {31'd0, flush_e});
    endtask

    // Full MC_LATENCY=4 sequence starting in the current cycle; optionally
    // raises a load-use hazard during the held cycles 0-2.
    task automatic run_mc_op(input string tag, input logic with_lw);
        bus.MultiCycleE = 1'b1;
        if (with_lw) begin
            bus.ResultSrcE = 1'b1; bus.RD_E = 5'd7; bus.Rs2_D = 5'd7;
        end
        #1 check_mc({tag, ".c0"}, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        check_mc({tag, ".c1"}, 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        check_mc({tag, ".c2"}, 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        bus.ResultSrcE = 1'b0; bus.RD_E = 5'd0; bus.Rs2_D = 5'd0;
        #1 check_mc({tag, ".c3"}, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        bus.MultiCycleE = 1'b0;
        #1 check_mc({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        clear_inputs();

        // Reset state.
        #3;
        check_val("rst.fwdA",   {30'd0, bus.ForwardA_E}, 32'd0);
        check_val("rst.start",  {31'd0, bus.MCStartE},   32'd0);
        check_val("rst.stallF", {31'd0, bus.StallF},     32'd0);
        check_val("rst.scnt",   bus.StallCount,          32'd0);
        check_val("rst.fcnt",   bus.FlushCount,          32'd0);
        #9 rst = 1'b1;
        next_cycle();

        // Forwarding: M and W both write x5, both sources read x5 -> M wins.
        bus.RD_M = 5'd5; bus.RegWriteM = 1'b1; bus.Rs1_E = 5'd5;
        bus.RD_W = 5'd5; bus.RegWriteW = 1'b1; bus.Rs2_E = 5'd5;
        #1 check_val("fwd.mw.A", {30'd0, bus.ForwardA_E}, 32'd2);
        check_val("fwd.mw.B", {30'd0, bus.ForwardB_E}, 32'd2);
        // M writes x6 (Rs2_E), W writes x5 (Rs1_E).
        bus.RD_M = 5'd6; bus.Rs2_E = 5'd6;
        #1 check_val("fwd.split.A", {30'd0, bus.ForwardA_E}, 32'd1);
        check_val("fwd.split.B", {30'd0, bus.ForwardB_E}, 32'd2);
        // M match without RegWriteM falls back to W/regfile.
        bus.RegWriteM = 1'b0; bus.RD_W = 5'd6;
        #1 check_val("fwd.nowe.A", {30'd0, bus.ForwardA_E}, 32'd0);
        check_val("fwd.nowe.B", {30'd0, bus.ForwardB_E}, 32'd1);
        // x0 never forwarded.
        bus.RD_M = 5'd0; bus.RegWriteM = 1'b1; bus.Rs1_E = 5'd0;
        bus.RD_W = 5'd0; bus.Rs2_E = 5'd0;
        #1 check_val("fwd.x0.A", {30'd0, bus.ForwardA_E}, 32'd0);
        check_val("fwd.x0.B", {30'd0, bus.ForwardB_E}, 32'd0);
        clear_inputs();

        // Load-use hazard.
        bus.ResultSrcE = 1'b1; bus.RD_E = 5'd7; bus.Rs2_D = 5'd7;
        #1 check_val("lw.stallF", {31'd0, bus.StallF}, 32'd1);
        check_val("lw.stallD", {31'd0, bus.StallD}, 32'd1);
        check_val("lw.flushE", {31'd0, bus.FlushE}, 32'd1);
        check_val("lw.flushD", {31'd0, bus.FlushD}, 32'd0);
        check_val("lw.stallE", {31'd0, bus.StallE}, 32'd0);
        // Redirect wins over load-use.
        bus.PCSrcE = 1'b1;
        #1 check_val("br.flushD", {31'd0, bus.FlushD}, 32'd1);
        check_val("br.flushE", {31'd0, bus.FlushE}, 32'd1);
        check_val("br.stallF", {31'd0, bus.StallF}, 32'd0);
        check_val("br.stallD", {31'd0, bus.StallD}, 32'd0);
        // Load to x0 is not a hazard.
        bus.PCSrcE = 1'b0; bus.RD_E = 5'd0; bus.Rs2_D = 5'd0; bus.Rs1_D = 5'd0;
        #1 check_val("lw.x0.stallF", {31'd0, bus.StallF}, 32'd0);
        check_val("lw.x0.flushE", {31'd0, bus.FlushE}, 32'd0);
        clear_inputs();
        next_cycle();

        // Multi-cycle op with a load-use hazard masked during the hold.
        run_mc_op("mc", 1'b1);
        // Back-to-back: a new op launches from IDLE.
        run_mc_op("mc2", 1'b0);

        // Reset in cycle 1 of an op.
        bus.MultiCycleE = 1'b1;
        #1 check_val("rmid.c0.start", {31'd0, bus.MCStartE}, 32'd1);
        next_cycle();
        check_val("rmid.c1.stallE", {31'd0, bus.StallE}, 32'd1);
        #2 rst = 1'b0;
        #1 check_val("rmid.rst.stallE", {31'd0, bus.StallE},   32'd0);
        check_val("rmid.rst.bubM",   {31'd0, bus.BubbleM},  32'd0);
        check_val("rmid.rst.start",  {31'd0, bus.MCStartE}, 32'd0);
        check_val("rmid.rst.done",   {31'd0, bus.MCDoneE},  32'd0);
        #1 rst = 1'b1;
        #1 check_mc("rmid.re.c0", 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        check_mc("rmid.re.c1", 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        check_mc("rmid.re.c2", 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        check_mc("rmid.re.c3", 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Performance counters: fresh reset, MC op (3 stall cycles) then one
        // load-use cycle (1 stall + 1 flush).
        rst = 1'b0;
        #2 rst = 1'b1;
        next_cycle();
        run_mc_op("perf.mc", 1'b1);
        bus.ResultSrcE = 1'b1; bus.RD_E = 5'd7; bus.Rs2_D = 5'd7;
        next_cycle();
        clear_inputs();
        next_cycle();
        next_cycle();
`ifdef HAZARD_PERF_CNT_EN
        check_val("perf.scnt", bus.StallCount, 32'd4);
        check_val("perf.fcnt", bus.FlushCount, 32'd1);
`else
        check_val("perf.scnt", bus.StallCount, 32'd0);
        check_val("perf.fcnt", bus.FlushCount, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
